muxn_reg: RTL and testbench
===========================

# muxn_reg

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake. It is the successor to the combinational 2:1 mux. It selects one of NCH input channels by a fixed select or by round-robin arbitration, then holds the winning word in a one-entry output register. It sits between multiple producer streams and a single consumer, and can stall back to the producers.

## Interface
- WIDTH, 8, data width per channel (>=1)
- NCH, 4, number of input channels (2..16)
- SELW, $clog2(NCH), select/channel-index width (derived, not overridden)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready; combinational, at most one bit high
- s  input  SELW  channel select, used in fixed mode
- mode  input  1  0 = fixed select (s), 1 = round-robin
- out_data  output  WIDTH  registered data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts
- out_ch  output  SELW  index of the channel that supplied out_data

## Operation
- Output register state: EMPTY (out_valid=0) or FULL (out_valid=1).
- can_accept = !out_valid | out_ready.
- Grant computation is combinational and yields at most one channel:
  - Fixed mode: grant channel s if in_valid[s]. If s >= NCH, or in_valid[s] is 0, there is no grant. Other channels' valids are ignored.
  - Round-robin mode: grant the first i with in_valid[i] set, searching ptr, ptr+1, … wrapping modulo NCH.
- in_ready[i] = grant[i] & can_accept. in_ready is never asserted for a channel with in_valid=0.
- Transfer in on channel g: out_data <= word g, out_ch <= g, out_valid <= 1.
- Transfer out (out_valid & out_ready) with no transfer in: out_valid <= 0. out_data and out_ch hold their values.
- Simultaneous transfer out and transfer in: the register reloads and out_valid stays 1. Full throughput is one word per cycle.
- ptr (SELW bits) updates only on a transfer in that occurs in round-robin mode. The new value is g+1, wrapping NCH-1 -> 0. A transfer in fixed mode leaves ptr unchanged.
- A mode or s change takes effect on the next grant evaluation. A word already held in the register is unaffected.
- out_data/out_ch must not change while out_valid=1 & out_ready=0. The hold is AXI-style: the register is stable until accepted.
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0. in_ready is therefore forced 0 for any channel without valid. Reset asserted mid-transfer discards the held word immediately (asynchronous).

## Timing
- Latency: input handshake at edge n, word visible on out_data/out_valid after edge n.
- in_ready depends combinationally on in_valid, s, mode, ptr, out_valid and out_ready. There is no combinational path from in_data to any output.
- Round-robin fairness: with all NCH channels continuously valid and out_ready=1, the grant order is ptr, ptr+1, …. Each channel is served once per NCH cycles.
- Reset deassertion must be synchronous to clk. This is the integrator's responsibility; the block has no internal synchroniser.

## Structure
- Package muxn_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1.
- Sub-module rr_arbiter:
  - Parameter NCH.
  - Inputs: req[NCH], ptr[SELW]. Outputs: one-hot gnt[NCH], gnt_idx[SELW], any.
  - Purely combinational.
  - muxn_reg instantiates it for round-robin mode and muxes against the fixed-select grant.
- The output register, ptr register and data mux live in muxn_reg.

## Test plan
- Reset/idle: rst=1 with all inputs random -> out_valid=0, out_data=0, out_ch=0. After release with no valids, in_ready=0.
- Fixed mode, NCH=4, WIDTH=8: s=2, in_valid=4'b1111, channel 2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2.
- Round-robin: all four valid continuously, out_ready=1, from reset -> out_ch sequence 0,1,2,3,0; in_ready one-hot each cycle.
- Backpressure: out_ready=0 for 3 cycles with a word held -> out_data/out_ch stable, in_ready=0. Then out_ready=1 with channel 1 valid -> simultaneous drain and reload, out_valid stays 1.
- Out-of-range select: NCH=3, mode fixed, s=3, all valid -> no in_ready for 5 cycles, out_valid remains 0.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid drops without waiting for an edge; after release round-robin restarts at channel 0.

Source files
------------

// File: rtl/muxn_pkg.sv
// Shared constants and types for the registered N-channel multiplexer.
// Mode encodings and the output-register state live here.
package muxn_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        OREG_EMPTY = 1'b0,
        OREG_FULL  = 1'b1
    } oreg_state_e;

endpackage : muxn_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo NCH. Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt,
    output logic [SELW-1:0] gnt_idx,
    output logic            any
);

    logic [NCH-1:0] w_thr;
    logic [NCH-1:0] w_hi;
    logic [NCH-1:0] w_pick;

    // Requests at or above ptr take priority; otherwise wrap to the lowest request.
    always_comb begin
        w_thr = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            w_thr[i] = (SELW'(i) >= ptr);
        end
        w_hi   = req & w_thr;
        w_pick = (|w_hi) ? w_hi : req;
    end

    // Isolate the lowest set bit of the chosen request vector.
    always_comb begin
        gnt     = w_pick & ~(w_pick - NCH'(1));
        gnt_idx = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (w_pick[i]) begin
                gnt_idx = SELW'(i);
            end
        end
        any = |req;
    end

endmodule : rr_arbiter

// File: rtl/muxn_reg.sv
// N-channel, W-bit registered multiplexer with valid/ready handshake, selecting
// by fixed index or round-robin and holding the winner in a one-entry register.
module muxn_reg
    import muxn_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic [SELW-1:0]        s,
    input  logic                   mode,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SELW-1:0]        out_ch
);

    oreg_state_e       r_state;
    oreg_state_e       w_state_nxt;
    logic [WIDTH-1:0]  r_out_data;
    logic [SELW-1:0]   r_out_ch;
    logic [SELW-1:0]   r_ptr;

    logic [NCH-1:0]    w_fix_gnt;
    logic [NCH-1:0]    w_rr_gnt;
    logic [SELW-1:0]   w_rr_idx;
    logic              w_rr_any;
    logic [NCH-1:0]    w_gnt;
    logic [SELW-1:0]   w_gnt_idx;
    logic              w_any;
    logic              w_can_accept;
    logic              w_xfer_in;
    logic [WIDTH-1:0]  w_word;
    logic [SELW-1:0]   w_ptr_nxt;

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx),
        .any     (w_rr_any)
    );

    // Fixed select: an out-of-range s simply matches no channel.
    always_comb begin
        w_fix_gnt = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            w_fix_gnt[i] = in_valid[i] && (s == SELW'(i));
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            w_gnt     = w_rr_gnt;
            w_gnt_idx = w_rr_idx;
            w_any     = w_rr_any;
        end else begin
            w_gnt     = w_fix_gnt;
            w_gnt_idx = s;
            w_any     = |w_fix_gnt;
        end
        w_can_accept = (r_state == OREG_EMPTY) || out_ready;
        w_xfer_in    = w_any && w_can_accept;
        in_ready     = w_gnt & {NCH{w_can_accept}};
    end

    // One-hot AND-OR data mux; the grant is at most one-hot.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (w_gnt[i]) begin
                w_word = w_word | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        if (w_gnt_idx == SELW'(NCH - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = SELW'(w_gnt_idx + SELW'(1));
        end
    end

    // Output register occupancy: reload keeps it full, a drain without reload empties it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OREG_EMPTY: begin
                if (w_xfer_in) begin
                    w_state_nxt = OREG_FULL;
                end
            end
            OREG_FULL: begin
                if (out_ready && !w_xfer_in) begin
                    w_state_nxt = OREG_EMPTY;
                end
            end
            default: w_state_nxt = OREG_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OREG_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Data/channel only move on a transfer in, so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_ptr      <= '0;
        end else if (w_xfer_in) begin
            r_out_data <= w_word;
            r_out_ch   <= w_gnt_idx;
            if (mode == MODE_RR) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out_valid = (r_state == OREG_FULL);
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule : muxn_reg

// File: tb/tb_muxn_reg.sv
// Directed bench for muxn_reg: a 4-channel instance for the main flows and a
// 3-channel instance for the out-of-range fixed select.
module tb_muxn_reg;

    logic        clk;
    logic        rst;

    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid;
    logic [3:0]  a_in_ready;
    logic [1:0]  a_s;
    logic        a_mode;
    logic [7:0]  a_out_data;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [1:0]  a_out_ch;

    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic [1:0]  b_s;
    logic        b_mode;
    logic [7:0]  b_out_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [1:0]  b_out_ch;

    int total = 0;
    int bad   = 0;

    muxn_reg #(.WIDTH(8), .NCH(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .s         (a_s),
        .mode      (a_mode),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_ch    (a_out_ch)
    );

    muxn_reg #(.WIDTH(8), .NCH(3)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .s         (b_s),
        .mode      (b_mode),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_ch    (b_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rr_word [4];
        rr_word[0] = 8'hA0;
        rr_word[1] = 8'hB1;
        rr_word[2] = 8'hC2;
        rr_word[3] = 8'hD3;

        rst         = 1'b1;
        a_in_data   = $urandom;
        a_in_valid  = 4'($urandom);
        a_s         = 2'($urandom);
        a_mode      = 1'($urandom);
        a_out_ready = 1'($urandom);
        b_in_data   = 24'($urandom);
        b_in_valid  = 3'($urandom);
        b_s         = 2'($urandom);
        b_mode      = 1'($urandom);
        b_out_ready = 1'($urandom);

        // Reset with random inputs
        step();
        chk("rst_valid", 32'(a_out_valid), 32'd0);
        chk("rst_data", 32'(a_out_data), 32'd0);
        chk("rst_ch", 32'(a_out_ch), 32'd0);
        chk("rst_b_valid", 32'(b_out_valid), 32'd0);
        a_in_valid = 4'($urandom);
        a_in_data  = $urandom;
        step();
        chk("rst_valid2", 32'(a_out_valid), 32'd0);
        chk("rst_data2", 32'(a_out_data), 32'd0);

        a_in_valid  = 4'b0000;
        a_mode      = 1'b0;
        a_s         = 2'd0;
        a_out_ready = 1'b1;
        b_in_valid  = 3'b000;
        b_mode      = 1'b0;
        b_s         = 2'd0;
        b_out_ready = 1'b1;
        rst         = 1'b0;
        #1;
        chk("idle_ready", 32'(a_in_ready), 32'd0);
        step();
        chk("idle_valid", 32'(a_out_valid), 32'd0);
        chk("idle_ready2", 32'(a_in_ready), 32'd0);

        // Fixed select s=2 with all channels valid
        a_in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        a_in_valid = 4'b1111;
        a_s        = 2'd2;
        #1;
        chk("fix_ready", 32'(a_in_ready), 32'h4);
        step();
        chk("fix_valid", 32'(a_out_valid), 32'd1);
        chk("fix_data", 32'(a_out_data), 32'hA5);
        chk("fix_ch", 32'(a_out_ch), 32'd2);
        a_in_valid = 4'b0000;
        #1;
        chk("fix_noreq", 32'(a_in_ready), 32'd0);
        step();
        chk("drain_valid", 32'(a_out_valid), 32'd0);
        chk("drain_hold", 32'(a_out_data), 32'hA5);

        // Round-robin from ptr=0 (fixed transfer must not have moved it)
        a_mode     = 1'b1;
        a_in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        a_in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(a_in_ready), 32'(1) << (k % 4));
            step();
            chk("rr_valid", 32'(a_out_valid), 32'd1);
            chk("rr_ch", 32'(a_out_ch), 32'(k % 4));
            chk("rr_data", 32'(a_out_data), 32'(rr_word[k % 4]));
        end

        // Backpressure holding ch0 word, ptr now 1
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(a_in_ready), 32'd0);
            step();
            chk("bp_valid", 32'(a_out_valid), 32'd1);
            chk("bp_data", 32'(a_out_data), 32'hA0);
            chk("bp_ch", 32'(a_out_ch), 32'd0);
        end
        a_out_ready = 1'b1;
        a_in_valid  = 4'b0010;
        #1;
        chk("reload_ready", 32'(a_in_ready), 32'h2);
        step();
        chk("reload_valid", 32'(a_out_valid), 32'd1);
        chk("reload_ch", 32'(a_out_ch), 32'd1);
        chk("reload_data", 32'(a_out_data), 32'hB1);

        // Fixed-mode transfer leaves ptr at 2
        a_mode     = 1'b0;
        a_s        = 2'd3;
        a_in_valid = 4'b1000;
        #1;
        chk("fix3_ready", 32'(a_in_ready), 32'h8);
        step();
        chk("fix3_ch", 32'(a_out_ch), 32'd3);
        chk("fix3_data", 32'(a_out_data), 32'hD3);
        a_mode     = 1'b1;
        a_in_valid = 4'b1111;
        #1;
        chk("ptr_kept", 32'(a_in_ready), 32'h4);
        step();
        chk("ptr_kept_ch", 32'(a_out_ch), 32'd2);

        // Wrap: ptr=3, only ch0 requests
        a_in_valid = 4'b0001;
        #1;
        chk("wrap_ready", 32'(a_in_ready), 32'h1);
        step();
        chk("wrap_ch", 32'(a_out_ch), 32'd0);

        // Out-of-range fixed select on the 3-channel instance
        b_in_data  = {8'h33, 8'h22, 8'h11};
        b_in_valid = 3'b111;
        b_s        = 2'd3;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("oor_ready", 32'(b_in_ready), 32'd0);
            step();
            chk("oor_valid", 32'(b_out_valid), 32'd0);
        end
        b_s = 2'd2;
        #1;
        chk("b_fix_ready", 32'(b_in_ready), 32'h4);
        step();
        chk("b_fix_ch", 32'(b_out_ch), 32'd2);
        chk("b_fix_data", 32'(b_out_data), 32'h33);

        // Asynchronous reset mid-cycle while holding a word
        a_out_ready = 1'b0;
        a_in_valid  = 4'b1111;
        #1;
        chk("pre_arst_valid", 32'(a_out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(a_out_valid), 32'd0);
        chk("arst_data", 32'(a_out_data), 32'd0);
        chk("arst_ch", 32'(a_out_ch), 32'd0);
        #1;
        rst         = 1'b0;
        a_out_ready = 1'b1;
        a_mode      = 1'b1;
        #1;
        chk("post_arst_ready", 32'(a_in_ready), 32'h1);
        step();
        chk("post_arst_ch0", 32'(a_out_ch), 32'd0);
        step();
        chk("post_arst_ch1", 32'(a_out_ch), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_muxn_reg
